// File: rtl/pwm_regs_pkg.sv
// Register map, timing constants and FSM states shared by the PWM ramp master.
// The PWM/LED slave decodes word addresses and answers reads one cycle after acceptance.
package pwm_regs_pkg;

  localparam logic [7:0] ADDR_PERIOD = 8'h00;
  localparam logic [7:0] ADDR_DUTY   = 8'h01;
  localparam logic [7:0] ADDR_COUNT  = 8'h02;

  localparam int PWM_READ_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_PERIOD,
    WR_DUTY,
    RD_DUTY,
    RD_WAIT,
    WAIT_STEP
  } state_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// Next point of the triangle duty ramp, clamped to 0 and PERIOD at the turning points.
// The sum is formed at 33 bits so a duty near the top of the word never wraps.
module pwm_ramp_step #(
  parameter int PERIOD    = 255,
  parameter int DUTY_STEP = 1
) (
  input  logic [31:0] duty,
  input  logic        up,
  output logic [31:0] next_duty,
  output logic        next_up
);

  logic [32:0] sum;

  always_comb begin
    sum       = {1'b0, duty} + 33'(DUTY_STEP);
    next_duty = duty;
    next_up   = up;
    if (up) begin
      if (sum >= 33'(PERIOD)) begin
        next_duty = 32'(PERIOD);
        next_up   = 1'b0;
      end else begin
        next_duty = sum[31:0];
      end
    end else begin
      if ({1'b0, duty} <= 33'(DUTY_STEP)) begin
        next_duty = '0;
        next_up   = 1'b1;
      end else begin
        next_duty = duty - 32'(DUTY_STEP);
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_master.sv
// Avalon-MM master that programs the PWM period once, then walks the duty register
// through a triangle wave, reading every duty write back and flagging any mismatch.
module pwm_ramp_master
  import pwm_regs_pkg::*;
#(
  parameter int PERIOD      = 255,
  parameter int DUTY_STEP   = 1,
  parameter int STEP_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [7:0]  m0_address,
  output logic        m0_read,
  output logic        m0_write,
  output logic [31:0] m0_writedata,
  input  logic [31:0] m0_readdata,
  input  logic        m0_waitrequest,
  output logic        busy,
  output logic [31:0] duty_level,
  output logic        error
);

  localparam int TW = $clog2(STEP_CYCLES + 1);

  // Handshake: a request (m0_read or m0_write, never both) is accepted on a rising
  // edge with m0_waitrequest low; until then address, read, write and writedata hold.
  state_t        state;
  logic [31:0]   duty;
  logic          dir_up;
  logic [TW-1:0] timer;
  logic [31:0]   next_duty;
  logic          next_up;
  logic          accepted;

  pwm_ramp_step #(
    .PERIOD   (PERIOD),
    .DUTY_STEP(DUTY_STEP)
  ) u_step (
    .duty     (duty),
    .up       (dir_up),
    .next_duty(next_duty),
    .next_up  (next_up)
  );

  assign accepted = (m0_read | m0_write) & ~m0_waitrequest;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      m0_address   <= '0;
      m0_read      <= 1'b0;
      m0_write     <= 1'b0;
      m0_writedata <= '0;
      duty_level   <= '0;
      error        <= 1'b0;
      duty         <= '0;
      dir_up       <= 1'b1;
      timer        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state        <= WR_PERIOD;
            m0_address   <= ADDR_PERIOD;
            m0_write     <= 1'b1;
            m0_writedata <= 32'(PERIOD);
          end
        end
        WR_PERIOD: begin
          if (accepted) begin
            if (enable) begin
              state        <= WR_DUTY;
              m0_address   <= ADDR_DUTY;
              m0_writedata <= duty;
            end else begin
              state        <= IDLE;
              m0_address   <= '0;
              m0_write     <= 1'b0;
              m0_writedata <= '0;
            end
          end
        end
        // A duty write is always followed by its readback, even if enable drops.
        WR_DUTY: begin
          if (accepted) begin
            duty_level   <= duty;
            state        <= RD_DUTY;
            m0_write     <= 1'b0;
            m0_writedata <= '0;
            m0_read      <= 1'b1;
          end
        end
        RD_DUTY: begin
          if (accepted) begin
            state      <= RD_WAIT;
            m0_read    <= 1'b0;
            m0_address <= '0;
          end
        end
        RD_WAIT: begin
          if (m0_readdata != duty_level) error <= 1'b1;
          timer <= TW'(STEP_CYCLES - 1);
          if (enable) begin
            state <= WAIT_STEP;
          end else begin
            // The step is complete, so a later restart resumes at the next ramp point.
            state  <= IDLE;
            duty   <= next_duty;
            dir_up <= next_up;
          end
        end
        WAIT_STEP: begin
          if (!enable) begin
            state  <= IDLE;
            duty   <= next_duty;
            dir_up <= next_up;
          end else if (timer == '0) begin
            state        <= WR_DUTY;
            duty         <= next_duty;
            dir_up       <= next_up;
            m0_address   <= ADDR_DUTY;
            m0_write     <= 1'b1;
            m0_writedata <= next_duty;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_ramp_master.md
Name: pwm_ramp_master

Overview:
- Avalon-MM master that drives the team's PWM/LED slave (period at 0x00, duty at 0x01, count at 0x02; read latency fixed at 1 cycle) to produce an autonomous "breathing" LED.
- After enable, it writes the period once. It then ramps duty in a triangle wave (0 to PERIOD and back), one step every STEP_CYCLES clocks.
- Every duty write is read back and checked; a mismatch sets a sticky error flag.
- Sits in the fabric beside the host CPU, which it replaces as the source of PWM settings.

Parameters:
- PERIOD, 255, value written to the period register and upper bound of the duty ramp (≥1).
- DUTY_STEP, 1, duty increment or decrement per step (1..PERIOD).
- STEP_CYCLES, 50000, clocks between the end of one step's readback and the next duty write (≥1).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request, level-sensitive.
- m0_address  out  8  Avalon-MM word address.
- m0_read  out  1  read request.
- m0_write  out  1  write request.
- m0_writedata  out  32  write data.
- m0_readdata  in  32  read data, valid exactly 1 cycle after read acceptance.
- m0_waitrequest  in  1  slave stall.
- busy  out  1  high whenever state ≠ IDLE.
- duty_level  out  32  last duty value accepted by the slave.
- error  out  1  sticky readback-mismatch flag.

Behaviour:
- Reset values: all m0_* outputs 0; busy 0; duty_level 0; error 0; internal duty 0, direction up, timer 0, state IDLE. Reset mid-transaction aborts it: outputs drop at the next edge and nothing is held.
- Acceptance: a transfer is accepted on a rising edge where (m0_read | m0_write) = 1 and m0_waitrequest = 0.
- Stall rule: while m0_waitrequest = 1, m0_address, m0_read, m0_write and m0_writedata are held stable. Read and write are never asserted together.
- IDLE: if enable = 1, go to WR_PERIOD.
- WR_PERIOD: drive address 0x00, write = 1, writedata = PERIOD. On acceptance go to WR_DUTY.
- WR_DUTY: drive address 0x01, write = 1, writedata = duty. On acceptance, duty_level ← duty and go to RD_DUTY.
- RD_DUTY: drive address 0x01, read = 1. On acceptance go to RD_WAIT.
- RD_WAIT: outputs idle. Sample m0_readdata at the end of this cycle. If it ≠ duty_level, error ← 1. Timer ← STEP_CYCLES−1, go to WAIT_STEP.
- WAIT_STEP: timer decrements each cycle. At 0, compute the next duty and go to WR_DUTY.
- Ramp, direction up:
  - duty + DUTY_STEP ≥ PERIOD → duty = PERIOD, direction ← down.
  - otherwise duty += DUTY_STEP.
- Ramp, direction down:
  - duty ≤ DUTY_STEP → duty = 0, direction ← up.
  - otherwise duty −= DUTY_STEP.
- Ramp arithmetic uses 33-bit sums, so there is no wrap-around.
- enable deassert:
  - In WR_*/RD_DUTY: finish the pending transfer; for RD_DUTY also complete RD_WAIT and the check. Then go to IDLE.
  - In WAIT_STEP: go to IDLE on the next edge.
  - duty, direction and duty_level are retained. Re-enable restarts at WR_PERIOD and continues the ramp from the retained duty.
- Error clears only on reset.
- Timer width is $clog2(STEP_CYCLES+1).
- Latency, zero-wait slave: enable high to the first write request takes 1 cycle. Each step is write(1) + read(1) + RD_WAIT(1) + STEP_CYCLES.

Decomposition:
- Shared package pwm_regs_pkg, holding:
  - ADDR_PERIOD = 8'h00, ADDR_DUTY = 8'h01, ADDR_COUNT = 8'h02;
  - PWM_READ_LATENCY = 1;
  - the state enum {IDLE, WR_PERIOD, WR_DUTY, RD_DUTY, RD_WAIT, WAIT_STEP}.
- Sub-module pwm_ramp_step: combinational next-duty/next-direction from (duty, dir, PERIOD, DUTY_STEP), with the clamp rules above.

Test Plan:
- PERIOD=4, DUTY_STEP=2, STEP_CYCLES=3, zero-wait slave model, enable=1 → writes in order: (0x00,4), (0x01,0), (0x01,2), (0x01,4), (0x01,2), (0x01,0), (0x01,2). Consecutive duty writes are 6 cycles apart. error stays 0.
- Same configuration, but the slave raises waitrequest for 5 cycles on the 2nd duty write → address/write/writedata=2 held stable all 5 cycles, exactly one write accepted, no read issued during the stall.
- PERIOD=5, DUTY_STEP=2 → duty sequence 0,2,4,5,3,1,0,2. Clamping occurs at both ends.
- Slave model returns readdata = written+1 on the 3rd readback → error rises at the end of that RD_WAIT and stays 1 while the ramp continues; reset clears it.
- enable dropped in the same cycle WR_DUTY(duty=2) is stalled → write completes, readback and check complete, then IDLE with busy=0. Re-enable → (0x00,PERIOD) is rewritten, then the next duty write is 4.
- Reset asserted mid-RD_DUTY with waitrequest=1 → the next edge shows all m0_* = 0, duty_level=0, state IDLE. After release with enable=1, the sequence restarts at (0x00,PERIOD), then (0x01,0).
